// File: rtl/nios2_div_pkg.sv
// Shared definitions for the Nios II iterative divide cell: FSM state
// encoding and the fixed constants used by the datapath.
package nios2_div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient returned for a zero divisor (all ones).
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage : nios2_div_pkg

// File: rtl/nios2_div_negate.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes before the divide and to restore result signs afterwards.
module nios2_div_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] operand,
    input  logic         neg,
    output logic [W-1:0] result
);

    logic [W-1:0] one_s;
    logic [W-1:0] negated_s;

    assign one_s     = {{(W-1){1'b0}}, 1'b1};
    assign negated_s = (~operand) + one_s;

    // Select the negated or pass-through value.
    always_comb begin
        result = operand;
        if (neg) begin
            result = negated_s;
        end else begin
            result = operand;
        end
    end

endmodule : nios2_div_negate

// File: rtl/nios2_div_cell.sv
// Nios II divide cell: radix-2 restoring divider producing one quotient
// bit per clock, with a start/busy/done handshake toward the A-stage
// stall logic. Signed operation divides magnitudes and fixes up signs at
// the end (truncating division, remainder takes the dividend's sign).
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder,
    output logic             A_div_busy,
    output logic             A_div_done
);

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(WIDTH);

    div_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;       // partial remainder
    logic [WIDTH-1:0] dvd_r;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_r;       // divisor magnitude
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dz_r;        // divide-by-zero in flight
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;

    logic             src1_neg_s;
    logic             src2_neg_s;
    logic [WIDTH-1:0] src1_abs_s;
    logic [WIDTH-1:0] src2_abs_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    assign src1_neg_s = A_div_signed & A_div_src1[WIDTH-1];
    assign src2_neg_s = A_div_signed & A_div_src2[WIDTH-1];

    nios2_div_negate #(.W(WIDTH)) u_abs_src1 (
        .operand (A_div_src1),
        .neg     (src1_neg_s),
        .result  (src1_abs_s)
    );

    nios2_div_negate #(.W(WIDTH)) u_abs_src2 (
        .operand (A_div_src2),
        .neg     (src2_neg_s),
        .result  (src2_abs_s)
    );

    nios2_div_negate #(.W(WIDTH)) u_fix_quot (
        .operand (dvd_r),
        .neg     (q_neg_r),
        .result  (q_fix_s)
    );

    nios2_div_negate #(.W(WIDTH)) u_fix_rem (
        .operand (rem_r),
        .neg     (r_neg_r),
        .result  (r_fix_s)
    );

    // Trial subtraction at WIDTH+1 bits; the sign bit tells whether the
    // shifted remainder covers the divisor.
    assign rem_sh_s   = {rem_r, dvd_r[WIDTH-1]};
    assign trial_s    = rem_sh_s - {1'b0, dsr_r};
    assign trial_ok_s = ~trial_s[WIDTH];

    // Control FSM and datapath registers, including registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= ZERO_W;
            dvd_r       <= ZERO_W;
            dsr_r       <= ZERO_W;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dz_r        <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (A_div_start) begin
                        q_neg_r <= src1_neg_s ^ src2_neg_s;
                        r_neg_r <= src1_neg_s;
                        dsr_r   <= src2_abs_s;
                        busy_r  <= 1'b1;
                        if (A_div_src2 == ZERO_W) begin
                            // Remainder magnitude with r_neg restores the
                            // original dividend in FIXUP.
                            dz_r    <= 1'b1;
                            dvd_r   <= ONES_W;
                            rem_r   <= src1_abs_s;
                            state_r <= FIXUP;
                        end else begin
                            dz_r    <= 1'b0;
                            dvd_r   <= src1_abs_s;
                            rem_r   <= ZERO_W;
                            cnt_r   <= CNT_LD;
                            state_r <= RUN;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (trial_ok_s) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        dvd_r <= {dvd_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_sh_s[WIDTH-1:0];
                        dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= FIXUP;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIXUP: begin
                    if (dz_r) begin
                        quotient_r <= DIV_ZERO_QUOT[WIDTH-1:0];
                    end else begin
                        quotient_r <= q_fix_s;
                    end
                    remainder_r <= r_fix_s;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    // Any start seen here is dropped on purpose.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign A_div_quotient  = quotient_r;
    assign A_div_remainder = remainder_r;
    assign A_div_busy      = busy_r;
    assign A_div_done      = done_r;

endmodule : nios2_div_cell

// File: tb/tb_nios2_div_cell.sv
// Self-checking bench for nios2_div_cell: expected results are queued
// when a divide is launched and compared when the done pulse appears.
module tb_nios2_div_cell;

    logic        clk;
    logic        reset;
    logic        A_div_start;
    logic        A_div_signed;
    logic [31:0] A_div_src1;
    logic [31:0] A_div_src2;
    logic [31:0] A_div_quotient;
    logic [31:0] A_div_remainder;
    logic        A_div_busy;
    logic        A_div_done;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    nios2_div_cell dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_start     (A_div_start),
        .A_div_signed    (A_div_signed),
        .A_div_src1      (A_div_src1),
        .A_div_src2      (A_div_src2),
        .A_div_quotient  (A_div_quotient),
        .A_div_remainder (A_div_remainder),
        .A_div_busy      (A_div_busy),
        .A_div_done      (A_div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: truncating division on magnitudes, signs restored.
    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] ma;
        logic [31:0] mb;
        logic        an;
        logic        bn;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else begin
            an = sgn & a[31];
            bn = sgn & b[31];
            ma = an ? (32'd0 - a) : a;
            mb = bn ? (32'd0 - b) : b;
            e.q = ma / mb;
            e.r = ma % mb;
            if (an ^ bn) e.q = 32'd0 - e.q;
            if (an)      e.r = 32'd0 - e.r;
        end
        return e;
    endfunction

    // Scoreboard: compare results on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (A_div_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, A_div_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", A_div_quotient, e.q);
                check("remainder", A_div_remainder, e.r);
            end
        end
    end

    // Drive a start at the current negedge, queue its expectation, and
    // return just after the start-sampling edge.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        A_div_start  = 1'b1;
        A_div_signed = sgn;
        A_div_src1   = a;
        A_div_src2   = b;
        if (push) sb.push_back(model(sgn, a, b));
        @(posedge clk);
    endtask

    // Follow an accepted divide to its done pulse, checking latency and
    // the number of busy cycles; ends at the negedge where done is high.
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int n;
        int nb;
        n  = 1;
        nb = 0;
        @(negedge clk);
        A_div_start = 1'b0;
        while (A_div_done !== 1'b1 && n < 200) begin
            if (A_div_busy === 1'b1) nb++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", n, exp_lat);
        check("busy_cycles", nb, exp_busy);
        check("busy_in_done", {31'd0, A_div_busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        A_div_start  = 1'b0;
        A_div_signed = 1'b0;
        A_div_src1   = 32'd0;
        A_div_src2   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_quot", A_div_quotient, 32'd0);
        check("rst_rem", A_div_remainder, 32'd0);
        check("rst_busy", {31'd0, A_div_busy}, 32'd0);
        check("rst_done", {31'd0, A_div_done}, 32'd0);

        // Basic unsigned divide with full latency check.
        launch(1'b0, 32'd100, 32'd7, 1'b1);
        wait_done(34, 33);
        @(negedge clk);
        check("done_one_cycle", {31'd0, A_div_done}, 32'd0);
        check("hold_quot", A_div_quotient, 32'd14);

        // Signed, divide-by-zero and boundary cases.
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(34, 33);
        @(negedge clk);
        launch(1'b0, 32'd5, 32'd0, 1'b1);
        wait_done(2, 1);
        @(negedge clk);
        launch(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1);
        wait_done(2, 1);
        @(negedge clk);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(34, 33);
        @(negedge clk);
        launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(34, 33);
        @(negedge clk);
        launch(1'b1, 32'd17, 32'hFFFF_FFFB, 1'b1);
        wait_done(34, 33);
        @(negedge clk);

        // Start while busy is ignored; outputs keep the previous result.
        launch(1'b0, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        A_div_start = 1'b0;
        repeat (8) @(negedge clk);
        A_div_start = 1'b1;
        A_div_src1  = 32'd9;
        A_div_src2  = 32'd3;
        @(negedge clk);
        A_div_start = 1'b0;
        check("hold_while_busy", A_div_quotient, 32'hFFFF_FFFD);
        begin
            int guard;
            guard = 0;
            while (A_div_done !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("ovl_done_seen", {31'd0, A_div_done}, 32'd1);
        end
        // Start during the done cycle is dropped; the next IDLE start wins.
        A_div_start = 1'b1;
        A_div_src1  = 32'd50;
        A_div_src2  = 32'd5;
        @(negedge clk);
        launch(1'b0, 32'd9, 32'd3, 1'b1);
        wait_done(34, 33);
        @(negedge clk);

        // Reset mid-operation abandons the divide.
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        A_div_start = 1'b0;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, A_div_busy}, 32'd0);
        check("mid_rst_quot", A_div_quotient, 32'd0);
        check("mid_rst_rem", A_div_remainder, 32'd0);
        repeat (40) @(negedge clk);
        launch(1'b0, 32'd100, 32'd7, 1'b1);
        wait_done(34, 33);
        @(negedge clk);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nios2_div_cell

// File: doc/nios2_div_cell.md
Name: nios2_div_cell

Overview:
- Iterative radix-2 restoring divider; the inverse-operation companion to the Nios II multiply cell in the custom-ALU path.
- Computes quotient and remainder of A_div_src1 / A_div_src2 for div/divu, one quotient bit per clock.
- Start/done handshake toward the A-stage stall logic.
- Sits beside the multiply cell; results are muxed into the A-stage result bus.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- A_div_start  in  1  request strobe; sampled only in IDLE.
- A_div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- A_div_src1  in  WIDTH  dividend; sampled with start.
- A_div_src2  in  WIDTH  divisor; sampled with start.
- A_div_quotient  out  WIDTH  quotient, registered.
- A_div_remainder  out  WIDTH  remainder, registered.
- A_div_busy  out  1  high from the cycle after start is accepted until done.
- A_div_done  out  1  one-cycle pulse when results are valid.

Behaviour:
- Reset: state=IDLE. quotient, remainder, busy, done and all internal registers are 0.
- Reset has priority over everything, including mid-operation. Any in-flight divide is abandoned and no done pulse is produced.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - On start=1, capture the sign flags: q_neg = signed & (src1[MSB] ^ src2[MSB]); r_neg = signed & src1[MSB].
  - Capture magnitudes: absolute values when signed, raw values otherwise. Magnitudes are treated as WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
  - Divisor == 0: go to FIXUP with raw quotient = all-ones and raw remainder = src1 magnitude.
  - Divisor != 0: clear the partial remainder, load cnt = WIDTH, go to RUN.
- RUN, each cycle:
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted - divisor, computed at WIDTH+1 bits.
  - trial non-negative: rem = trial and shift in quotient bit 1. Otherwise keep rem and shift in 0.
  - Decrement cnt. When cnt reaches 1 (last iteration), go to FIXUP.
  - Exactly WIDTH RUN cycles.
- FIXUP:
  - A_div_quotient = q_neg ? -q : q.
  - A_div_remainder = r_neg ? -r : r.
  - Divide-by-zero skips sign fixup: quotient = 0xFFFFFFFF, remainder = original src1.
  - Go to DONE.
- DONE: done=1 for this single cycle, busy=0, return to IDLE.
  - A start presented in this cycle is ignored.
  - A start in the following IDLE cycle is accepted (back-to-back throughput WIDTH+3).
- busy is 1 in RUN and FIXUP, 0 in IDLE and DONE.
- Latency, counted from the start-sampling edge:
  - done high in the cycle after edge WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: done after edge 2.
- Outputs hold their last result until FIXUP of the next operation; they are not cleared by a new start.
- start while busy or in DONE: ignored, with no effect on operands or flags.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, with no special case.
- Remainder sign follows the dividend (truncating division, Nios II semantics).

Decomposition:
- Shared package nios2_div_pkg:
  - State enum typedef (IDLE/RUN/FIXUP/DONE).
  - Constants DIV_WIDTH=32 and DIV_ZERO_QUOT='1.
- One natural sub-module: nios2_div_negate. Conditional two's-complement negate (in, neg -> out), instantiated for the operand abs step and the result fixup.
- Core FSM and datapath stay in the top module.

Test Plan:
- Unsigned 100 / 7, start for 1 cycle -> busy high for 33 cycles; done pulse at cycle 34; quotient 14, remainder 2.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Unsigned 5 / 0 -> done after 2 cycles; quotient 0xFFFFFFFF, remainder 5.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Start 100/7, then pulse start with 9/3 at cycle 10 -> second start ignored; results 14/2. Fresh start in the IDLE cycle after done -> 9/3 gives quotient 3, remainder 0.
- Start, then assert reset at cycle 15 -> next cycle: busy 0, outputs 0, and no done pulse ever. A new start afterwards completes normally.
